// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a length-prefixed byte
// stream, writes 32-bit words and holds the CPU in reset until done.
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        byte_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        DONE,
        ERR
    } state_t;

    state_t            state;
    logic [7:0]        cnt_lo;
    logic [ADDR_W-1:0] widx;
    logic [ADDR_W-1:0] last;
    logic [1:0]        bidx;
    logic [23:0]       lanes;
    logic              xfer;
    logic [15:0]       n;

    assign xfer = valid_i && ready_o;
    assign n    = {byte_i, cnt_lo};

    // Status flags come straight from the state register.
    assign ready_o   = (state == HDR_LO) || (state == HDR_HI) || (state == DATA);
    assign done_o    = (state == DONE);
    assign err_o     = (state == ERR);
    assign cpu_rst_o = (state != DONE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= HDR_LO;
            cnt_lo      <= '0;
            widx        <= '0;
            last        <= '0;
            bidx        <= '0;
            lanes       <= '0;
            imem_we_o   <= 1'b0;
            imem_addr_o <= '0;
            imem_data_o <= '0;
        end else begin
            imem_we_o <= 1'b0;
            if (xfer) begin
                unique case (state)
                    HDR_LO: begin
                        cnt_lo <= byte_i;
                        state  <= HDR_HI;
                    end
                    HDR_HI: begin
                        if (n == 16'd0) begin
                            state <= DONE;
                        end else if ({1'b0, n} > 17'(DEPTH)) begin
                            state <= ERR;
                        end else begin
                            state <= DATA;
                            widx  <= '0;
                            bidx  <= '0;
                            last  <= ADDR_W'(n - 16'd1);
                        end
                    end
                    DATA: begin
                        bidx <= bidx + 2'd1;
                        unique case (bidx)
                            2'd0: lanes[7:0]   <= byte_i;
                            2'd1: lanes[15:8]  <= byte_i;
                            2'd2: lanes[23:16] <= byte_i;
                            2'd3: begin
                                imem_we_o   <= 1'b1;
                                imem_addr_o <= widx;
                                imem_data_o <= {byte_i, lanes};
                                // Final word: stop here so the index never passes N-1.
                                if (widx == last) begin
                                    state <= DONE;
                                end else begin
                                    widx <= widx + 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
